// File: rtl/beam_pkg.sv
// Shared constants and types for the delay-and-sum beamformer.
package beam_pkg;

  localparam int NCH           = 4;
  localparam int DEPTH_DEFAULT = 32;
  localparam int W_DEFAULT     = 8;
  localparam int DW_DEFAULT    = 5;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    ACC,
    OUT
  } state_t;

endpackage

// File: rtl/delay_ram.sv
// Per-channel circular delay lines packed into one single-port RAM.
// Address is {channel, pointer}; registered read, no reset so it maps to block RAM.
module delay_ram
  import beam_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int AW    = $clog2(NCH * DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [NCH*DEPTH];

  // Synchronous write, read-first registered read on the same port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/beam_summer.sv
// Delay-and-sum beamformer: captures four channels on each new-sample edge,
// writes them into circular delay lines, reads each back at its own steering
// delay and outputs the unsigned sum with a one-cycle valid pulse.
module beam_summer
  import beam_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int W     = W_DEFAULT,
  parameter int DW    = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          sample_in,
  input  logic [W-1:0]  ch0,
  input  logic [W-1:0]  ch1,
  input  logic [W-1:0]  ch2,
  input  logic [W-1:0]  ch3,
  input  logic [DW-1:0] delay0,
  input  logic [DW-1:0] delay1,
  input  logic [DW-1:0] delay2,
  input  logic [DW-1:0] delay3,
  output logic [W+1:0]  beam,
  output logic          beam_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int              IW       = $clog2(NCH);
  localparam int              AW       = IW + DW;
  localparam logic [IW-1:0]   IDX_LAST = IW'(NCH - 1);
  localparam logic [DW:0]     FILL_MAX = (DW+1)'(DEPTH);

  // Synchronizer and edge detect
  logic s1_q, s2_q, s3_q;
  logic edge_det;

  // Control
  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          start;

  // Per-sample captured data and delays
  logic [W-1:0]  ch_in  [NCH];
  logic [DW-1:0] dly_in [NCH];
  logic [W-1:0]  cap_q  [NCH];
  logic [DW-1:0] dly_q  [NCH];

  // Delay-line bookkeeping; fill_q counts samples already written, saturating
  logic [DW-1:0] wr_ptr_q;
  logic [DW:0]   fill_q;

  // Read pipeline and accumulator
  logic          rd_pend_q;
  logic [IW-1:0] rd_idx_q;
  logic [W+1:0]  acc_q;
  logic [W-1:0]  contrib;

  // Outputs
  logic [W+1:0]  beam_q;
  logic          beam_valid_q;
  logic          overrun_q;

  // RAM port
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;

  assign ch_in[0]  = ch0;
  assign ch_in[1]  = ch1;
  assign ch_in[2]  = ch2;
  assign ch_in[3]  = ch3;
  assign dly_in[0] = delay0;
  assign dly_in[1] = delay1;
  assign dly_in[2] = delay2;
  assign dly_in[3] = delay3;

  assign edge_det = s2_q & ~s3_q;
  assign start    = (state_q == IDLE) && edge_det;

  // Two-flop synchronizer plus edge flop for the new-sample level.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sample_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // State and channel-index registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: four write cycles, four read cycles, one drain, one output.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = WR;
          idx_d   = '0;
        end
      end
      WR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = RD;
          idx_d   = '0;
        end
      end
      RD: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = ACC;
          idx_d   = '0;
        end
      end
      ACC:     state_d = OUT;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture samples and steering delays only when an operation starts.
  always_ff @(posedge clk) begin
    if (start) begin
      for (int k = 0; k < NCH; k++) begin
        cap_q[k] <= ch_in[k];
        dly_q[k] <= dly_in[k];
      end
    end
  end

  // RAM address: write slot is the current pointer, read slot trails it by the delay.
  always_comb begin
    ram_we    = (state_q == WR);
    ram_wdata = cap_q[idx_q];
    ram_addr  = {idx_q, wr_ptr_q};
    if (state_q == RD) begin
      ram_addr = {idx_q, wr_ptr_q - dly_q[idx_q]};
    end
  end

  // A delay reaching beyond what has been written reads stale RAM, so it adds zero.
  always_comb begin
    contrib = '0;
    if ({1'b0, dly_q[rd_idx_q]} <= fill_q) begin
      contrib = ram_rdata;
    end
  end

  // Datapath: read pipeline, accumulator, pointer/fill bookkeeping and outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_pend_q    <= 1'b0;
      rd_idx_q     <= '0;
      acc_q        <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      beam_q       <= '0;
      beam_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_pend_q    <= (state_q == RD);
      rd_idx_q     <= idx_q;
      beam_valid_q <= (state_q == OUT);

      if (start) begin
        acc_q <= '0;
      end else if (rd_pend_q) begin
        acc_q <= acc_q + {2'b00, contrib};
      end

      if (state_q == OUT) begin
        beam_q   <= acc_q;
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + 1'b1;
        end
      end

      if (edge_det && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  delay_ram #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign beam       = beam_q;
  assign beam_valid = beam_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule

// File: doc/beam_summer.md
# beam_summer

Delay-and-sum beamformer stage downstream of `adc_sampler`. On each new-sample strobe it captures the four 8-bit microphone channels and stores them in per-channel circular delay lines. It then reads each channel back at its own programmable steering delay and outputs the 10-bit sum with a one-cycle valid pulse. It replaces the direct ch0-to-RAM capture path and feeds the sample RAM, LEDs, and any later stage with a steered beam.

## Interface
Parameters:
- `DEPTH`, 32: delay-line length per channel, in samples (power of two).
- `W`, 8: sample width, unsigned offset-binary from the ADC.
- `DW`, 5: delay width, log2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; the only clock.
- `n_reset`  in  1  asynchronous, active-low reset.
- `sample_in`  in  1  `newSample` level from `adc_sampler`; a 0→1 transition marks a new sample set.
- `ch0`..`ch3`  in  `W` each  channel samples, stable while `sample_in` is high.
- `delay0`..`delay3`  in  `DW` each  steering delay per channel, in samples (0 = current sample).
- `beam`  out  `W`+2  delay-and-sum result, held until the next result.
- `beam_valid`  out  1  one-cycle pulse when `beam` updates.
- `busy`  out  1  high while the FSM is outside IDLE.
- `overrun`  out  1  sticky; a sample edge arrived while busy. Cleared only by reset.

## Operation
- `sample_in` passes through a 2-flop synchronizer (s1, s2) plus an edge flop (s3).
- `edge` = s2 & ~s3.
- FSM states:
  - IDLE: on `edge`, latch `ch0..3` into `cap[0..3]` and `delay0..3` into `dly[0..3]`; go to WR with idx=0.
  - WR: write `cap[idx]` to address {idx, `wr_ptr`}; idx 0..3, one per cycle; after idx=3 go to RD with idx=0.
  - RD: read address {idx, (`wr_ptr` − `dly[idx]`) mod `DEPTH`}; the registered read data is added one cycle later; idx 0..3; after idx=3 go to ACC.
  - ACC: add the last read; go to OUT.
  - OUT: load `beam` from the accumulator; pulse `beam_valid`; advance `wr_ptr` (31→0 wrap); `fill` = min(`fill`+1, `DEPTH`); go to IDLE.
- Warm-up masking: `fill` counts samples written before the current one, plus one. A channel contributes 0 when `dly[k]` ≥ `fill`. Stale or uninitialised RAM is therefore never summed.
- Arithmetic:
  - Sum is unsigned: 4 × 255 = 1020 fits in 10 bits, so no saturation is needed.
  - The accumulator clears on the IDLE→WR transition.
- Delay inputs are sampled only at the IDLE→WR transition. Changes mid-operation affect the next sample only.
- An `edge` while not in IDLE:
  - sets `overrun`;
  - drops that sample (no capture, no `wr_ptr` change);
  - leaves the current operation unaffected.
- Reset values:
  - `beam`=0, `beam_valid`=0, `busy`=0, `overrun`=0.
  - `wr_ptr`=0, `fill`=0, state IDLE, synchronizer flops 0.
  - RAM contents are not reset.
- Reset mid-operation aborts with no `beam_valid`. `wr_ptr` and `fill` return to 0.

## Timing
- `sample_in` first sampled high at clk edge k (after being low):
  - s2 high at k+1;
  - IDLE→WR at k+2;
  - WR occupies cycles k+2..k+5;
  - RD occupies k+6..k+9;
  - ACC at k+10;
  - OUT at k+11;
  - `beam`/`beam_valid` registered high during cycle k+12.
- Fixed latency: 12 clocks from first high sample to `beam_valid`. `busy` is high for 10 cycles (k+2 through k+11).
- Minimum edge spacing without overrun: the next edge is detected no earlier than a cycle in IDLE, i.e. `sample_in` rising ≥ 11 clocks apart.
- `sample_in` held high indefinitely produces exactly one operation. The next operation needs a 0→1 transition.

## Structure
- Package `beam_pkg`:
  - `NCH`=4;
  - `DEPTH`, `W`, `DW` defaults;
  - `state_t` enum {IDLE, WR, RD, ACC, OUT}.
- Sub-module `delay_ram`: `NCH`·`DEPTH` × `W` single-port RAM, address {ch, ptr}, synchronous write, registered read, no reset. Maps to block RAM.
- Top `beam_summer` holds the synchronizer, FSM, capture/delay registers, pointer, fill counter, and accumulator.

## Test plan
- Reset then single sample: ch=10,20,30,40, delays all 0 → `beam`=100 at k+12, one-cycle `beam_valid`, `overrun`=0.
- Warm-up mask: first sample ch=50 each, delay0=3 and others 0 → `beam`=150. Repeat the same values for samples 2–4 → sample 4 `beam`=200.
- Steering: 40 samples where sample n has ch_k=n, delays 0,1,2,3 → sample 40 `beam`=40+39+38+37=154. `wr_ptr` wraps past 31 with correct values.
- Max sum: all channels 255, delays 0 → `beam`=1020, no wrap.
- Overrun: second `sample_in` rise 5 clocks after the first → `overrun`=1 sticky, only one `beam_valid`, `wr_ptr` advances by 1.
- Reset mid-RD: assert `n_reset` at k+7 → no `beam_valid`, all outputs 0. The next sample behaves as the first after reset (masking active).
